// File: rtl/uart_loader.sv
`default_nettype none
// ==========================================================================
// uart_loader : 8N1 receiver + load-packet decoder writing work RAM, holds CPU.
//   Trailing checksum byte enabled by defining UART_LOADER_CHECKSUM_EN.
//   Revision 1.0
// ==========================================================================
module uart_loader #(
  parameter int         ADDR_W = 16,
  parameter int         LEN_W  = 16,
  parameter logic [7:0] HEADER = 8'h55
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_tick,
  input  logic              rxd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CHK
  } pkt_state_t;

  // ---------------- receiver ----------------
  logic       rxd_meta, rxd_sync, rxd_prev;
  rx_state_t  rx_state, rx_state_n;
  logic [3:0] tick_cnt, tick_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] rx_byte, rx_byte_n;
  logic       byte_valid, byte_valid_n;
  logic       frame_err, frame_err_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta   <= 1'b1;
      rxd_sync   <= 1'b1;
      rxd_prev   <= 1'b1;
      rx_state   <= RX_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rxd_meta   <= rxd;
      rxd_sync   <= rxd_meta;
      rxd_prev   <= rxd_sync;
      rx_state   <= rx_state_n;
      tick_cnt   <= tick_cnt_n;
      bit_cnt    <= bit_cnt_n;
      rx_byte    <= rx_byte_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    tick_cnt_n   = tick_cnt;
    bit_cnt_n    = bit_cnt;
    rx_byte_n    = rx_byte;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rxd_prev && !rxd_sync) begin
          rx_state_n = RX_START;
          tick_cnt_n = '0;
        end
      end
      RX_START: begin
        // Half a bit in: re-check the start bit to reject glitches.
        if (rx_tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd7) begin
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            rx_state_n = rxd_sync ? RX_IDLE : RX_BITS;
          end
        end
      end
      RX_BITS: begin
        if (rx_tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            rx_byte_n = {rxd_sync, rx_byte[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state_n = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          tick_cnt_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            rx_state_n   = RX_IDLE;
            byte_valid_n = rxd_sync;
            frame_err_n  = !rxd_sync;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- packet decoder ----------------
  pkt_state_t        state, state_n;
  logic [7:0]        field_hi, field_hi_n;
  logic [LEN_W-1:0]  remain, remain_n;
  logic [7:0]        sum, sum_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        data_n;
  logic              we_n, hold_n, done_n, err_n;
  logic [ADDR_W-1:0] addr_field;
  logic [LEN_W-1:0]  len_field;

  assign addr_field = ADDR_W'({field_hi, rx_byte});
  assign len_field  = LEN_W'({field_hi, rx_byte});

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      field_hi <= '0;
      remain   <= '0;
      sum      <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      field_hi <= field_hi_n;
      remain   <= remain_n;
      sum      <= sum_n;
      mem_addr <= addr_n;
      mem_data <= data_n;
      mem_we   <= we_n;
      cpu_hold <= hold_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    field_hi_n = field_hi;
    remain_n   = remain;
    sum_n      = sum;
    addr_n     = mem_addr;
    data_n     = mem_data;
    we_n       = 1'b0;
    hold_n     = cpu_hold;
    done_n     = 1'b0;
    err_n      = err;
    if (frame_err) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
      hold_n  = 1'b0;
    end else if (mem_we) begin
      // Address/count bookkeeping happens the cycle after each write.
      addr_n   = mem_addr + 1'b1;
      remain_n = remain - 1'b1;
      if (remain == LEN_W'(1)) begin
        if (CHK_EN) begin
          state_n = S_CHK;
        end else begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          hold_n  = 1'b0;
        end
      end
    end else if (byte_valid) begin
      sum_n = sum + rx_byte;
      case (state)
        S_IDLE: begin
          if (rx_byte == HEADER) begin
            state_n = S_ADDR_H;
            hold_n  = 1'b1;
            err_n   = 1'b0;
            sum_n   = '0;
          end
        end
        S_ADDR_H: begin
          field_hi_n = rx_byte;
          state_n    = S_ADDR_L;
        end
        S_ADDR_L: begin
          addr_n  = addr_field;
          state_n = S_LEN_H;
        end
        S_LEN_H: begin
          field_hi_n = rx_byte;
          state_n    = S_LEN_L;
        end
        S_LEN_L: begin
          remain_n = len_field;
          if (len_field != '0) begin
            state_n = S_DATA;
          end else if (CHK_EN) begin
            state_n = S_CHK;
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            hold_n  = 1'b0;
          end
        end
        S_DATA: begin
          we_n   = 1'b1;
          data_n = rx_byte;
        end
        S_CHK: begin
          state_n = S_IDLE;
          hold_n  = 1'b0;
          if (rx_byte == sum) done_n = 1'b1;
          else                err_n  = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// tb_uart_loader: serial packet stimulus with a queue-based scoreboard for uart_loader.
module tb_uart_loader;
  localparam int CLK_PER_TICK = 2;
  localparam int CLK_PER_BIT  = 16 * CLK_PER_TICK;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int EV_WR = 0, EV_DONE = 1, EV_ERR = 2;

  typedef struct {
    int         kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_tick = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we, cpu_hold, done, err;

  int  checks = 0;
  int  failures = 0;
  ev_t exp_q[$];

  uart_loader #(.ADDR_W(16), .LEN_W(16), .HEADER(8'h55)) dut (
    .clk(clk), .reset(reset), .rx_tick(rx_tick), .rxd(rxd),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % CLK_PER_TICK;
      rx_tick = (div == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind %0d addr %0h data %0h, expected none",
               kind, mem_addr, mem_data);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EV_WR && e.kind == EV_WR) begin
        check("wr_addr", {16'h0, mem_addr}, {16'h0, e.addr});
        check("wr_data", {24'h0, mem_data}, {24'h0, e.data});
      end
    end
  endtask

  initial begin : monitor
    logic err_prev;
    err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        err_prev = 1'b0;
      end else begin
        if (mem_we) observe(EV_WR);
        if (done) observe(EV_DONE);
        if (err && !err_prev) observe(EV_ERR);
        err_prev = err;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    repeat (CLK_PER_BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CLK_PER_BIT) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (CLK_PER_BIT) @(negedge clk);
    rxd = 1'b1;
    repeat (CLK_PER_BIT) @(negedge clk);
  endtask

  // Reference: expected writes/outcome derived from the whole packet at once.
  task automatic run_packet(input logic [15:0] addr, input logic [7:0] data[$],
                            input int fe_idx, input bit bad_chk);
    logic [7:0] s[$];
    logic [7:0] sum;
    int         n;
    bit         exp_err;
    bit         ok;
    n = data.size();
    s = {8'h55, addr[15:8], addr[7:0], 8'(n >> 8), 8'(n)};
    foreach (data[j]) s.push_back(data[j]);
    sum = 8'h00;
    for (int k = 1; k < s.size(); k++) sum = sum + s[k];
    if (CHK_EN) s.push_back(bad_chk ? sum + 8'(1 + $urandom_range(0, 254)) : sum);
    for (int j = 0; j < n; j++)
      if (fe_idx < 0 || 5 + j < fe_idx) exp_q.push_back('{EV_WR, addr + 16'(j), data[j]});
    exp_err = (fe_idx >= 0) || (CHK_EN && bad_chk);
    if (exp_err) exp_q.push_back('{EV_ERR, 16'h0, 8'h0});
    else         exp_q.push_back('{EV_DONE, 16'h0, 8'h0});
    for (int k = 0; k < s.size(); k++) begin
      ok = (k != fe_idx);
      send_byte(s[k], ok);
      if (!ok) break;
      if (k == 0) check("err_clear_at_header", {31'h0, err}, 32'h0);
      if (k < s.size() - 1) check("hold_in_packet", {31'h0, cpu_hold}, 32'h1);
    end
    check("hold_after_packet", {31'h0, cpu_hold}, 32'h0);
    check("err_after_packet", {31'h0, err}, {31'h0, exp_err});
  endtask

  initial begin : stim
    logic [7:0] d[$];
    logic [7:0] b;
    int         n, fe, mode;
    bit         bad;
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_addr", {16'h0, mem_addr}, 32'h0);
    check("rst_data", {24'h0, mem_data}, 32'h0);
    check("rst_we",   {31'h0, mem_we},   32'h0);
    check("rst_hold", {31'h0, cpu_hold}, 32'h0);
    check("rst_done", {31'h0, done},     32'h0);
    check("rst_err",  {31'h0, err},      32'h0);
    reset = 1'b0;
    repeat (CLK_PER_BIT) @(negedge clk);

    send_byte(8'h00, 1'b1);
    send_byte(8'h7E, 1'b1);
    check("junk_ignored_hold", {31'h0, cpu_hold}, 32'h0);

    d = '{8'hAA, 8'hBB, 8'hCC};          run_packet(16'h1000, d, -1, 1'b0);
    d = '{8'h11, 8'h22};                 run_packet(16'hFFFF, d, -1, 1'b0);
    d = '{8'h5A};                        run_packet(16'h2000, d, -1, CHK_EN);
    d = {};                              run_packet(16'h3000, d, -1, 1'b0);
    d = '{8'h01, 8'h02};                 run_packet(16'h4000, d, 3, 1'b0);
    d = '{8'h55, 8'h55, 8'h10};          run_packet(16'h5000, d, -1, 1'b0);

    // Start-bit glitch shorter than half a bit.
    rxd = 1'b0;
    repeat (4 * CLK_PER_TICK) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * CLK_PER_BIT) @(negedge clk);
    check("glitch_hold", {31'h0, cpu_hold}, 32'h0);
    check("glitch_err",  {31'h0, err},      32'h0);

    // Reset after the first of three data writes.
    exp_q.push_back('{EV_WR, 16'h6000, 8'hC3});
    send_byte(8'h55, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'hC3, 1'b1);
    check("first_write_seen", exp_q.size(), 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_addr", {16'h0, mem_addr}, 32'h0);
    check("midrst_data", {24'h0, mem_data}, 32'h0);
    check("midrst_hold", {31'h0, cpu_hold}, 32'h0);
    check("midrst_we",   {31'h0, mem_we},   32'h0);
    reset = 1'b0;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h96, 1'b1);
    check("after_rst_hold", {31'h0, cpu_hold}, 32'h0);
    d = '{8'h3C, 8'h96, 8'hA5};          run_packet(16'h6000, d, -1, 1'b0);

    repeat (8) begin
      n = $urandom_range(0, 4);
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        b = 8'($urandom);
        if (b == 8'h55) b = 8'h54;
        send_byte(b, 1'b1);
      end
      mode = $urandom_range(0, 3);
      fe   = (mode == 2) ? $urandom_range(1, 4 + n + int'(CHK_EN)) : -1;
      bad  = (mode == 3);
      run_packet(16'($urandom), d, fe, bad);
    end

    repeat (4 * CLK_PER_BIT) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
